// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared definitions for the snake game core: heading
//               encodings, the direction-control FSM state encoding and a
//               helper returning the opposite heading.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Opposite headings differ only in the upper bit of the encoding.
    function automatic logic [1:0] reverse_dir(input logic [1:0] heading);
        return heading ^ 2'b10;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filtro_tecla.sv
`default_nettype none
// ============================================================================
// Module      : filtro_tecla
// Description : Decodes the w/a/s/d keys into a single direction candidate
//               and requires it to be sampled on STABLE consecutive edges
//               before it is accepted.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               enable          - filter runs when high, held cleared when low
//               w, a, s, d      - raw keys (up, left, down, right)
//               accept          - high on the edge the candidate is accepted
//               acc_dir[1:0]    - direction carried with accept
// Revision    : 1.0 - initial release
// ============================================================================
module filtro_tecla #(
    parameter int STABLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       w,
    input  logic       a,
    input  logic       s,
    input  logic       d,
    output logic       accept,
    output logic [1:0] acc_dir
);
    import snake_pkg::*;

    localparam int            CW       = $clog2(STABLE + 1);
    localparam logic [CW-1:0] C_STABLE = CW'(STABLE);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    logic [CW-1:0] stab_cnt;
    logic [CW-1:0] cnt_next;
    logic [1:0]    last_cand;
    logic [1:0]    cand;
    logic          cand_v;
    logic          restart;

    // Exactly one key pressed gives a candidate; anything else gives none.
    always_comb begin
        cand_v = 1'b0;
        cand   = DIR_UP;
        case ({w, a, s, d})
            4'b1000: begin cand_v = 1'b1; cand = DIR_UP;    end
            4'b0001: begin cand_v = 1'b1; cand = DIR_RIGHT; end
            4'b0010: begin cand_v = 1'b1; cand = DIR_DOWN;  end
            4'b0100: begin cand_v = 1'b1; cand = DIR_LEFT;  end
            default: begin cand_v = 1'b0; cand = DIR_UP;    end
        endcase
    end

    always_comb begin
        restart = !cand_v || (cand != last_cand);
        if (restart) begin
            cnt_next = cand_v ? C_ONE : '0;
        end else if (stab_cnt != C_STABLE) begin
            cnt_next = stab_cnt + C_ONE;
        end else begin
            cnt_next = stab_cnt;
        end
        // Fire only on the edge the count arrives at STABLE, not while it
        // sits saturated; a restart that lands on STABLE (STABLE=1) fires too.
        accept  = enable && cand_v && (cnt_next == C_STABLE) &&
                  (restart || (stab_cnt != C_STABLE));
        acc_dir = cand;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !enable) begin
            stab_cnt  <= '0;
            last_cand <= DIR_UP;
        end else begin
            stab_cnt  <= cnt_next;
            last_cand <= cand;
        end
    end

endmodule
`default_nettype wire

// File: rtl/controle_direcao.sv
`default_nettype none
// ============================================================================
// Module      : controle_direcao
// Description : Player-input front end for the snake core. Filters keys,
//               latches the last accepted request and commits it to the
//               heading on each periodic step, discarding 180-degree turns.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               start               - begins/restarts a game outside RUN
//               w, a, s, d          - raw keys (up, left, down, right)
//               game_over, win      - from core; stop stepping
//               dir[1:0]            - committed heading (registered)
//               step                - one-cycle advance pulse (registered)
//               running             - high while in RUN (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module controle_direcao #(
    parameter int TICK_DIV = 4,
    parameter int STABLE   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       w,
    input  logic       a,
    input  logic       s,
    input  logic       d,
    input  logic       game_over,
    input  logic       win,
    output logic [1:0] dir,
    output logic       step,
    output logic       running
);
    import snake_pkg::*;

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [1:0]    pending;
    logic          pend_v;
    logic          accept;
    logic [1:0]    acc_dir;
    logic          filt_en;

    // The filter is only live in RUN; leaving RUN clears it.
    assign filt_en = (state == ST_RUN);

    filtro_tecla #(
        .STABLE (STABLE)
    ) u_filtro (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (filt_en),
        .w       (w),
        .a       (a),
        .s       (s),
        .d       (d),
        .accept  (accept),
        .acc_dir (acc_dir)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            dir      <= DIR_RIGHT;
            step     <= 1'b0;
            running  <= 1'b0;
            tick_cnt <= '0;
            pending  <= DIR_UP;
            pend_v   <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        running  <= 1'b1;
                        tick_cnt <= '0;
                        pend_v   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Stop requests win over a step landing on the same edge.
                    if (game_over || win) begin
                        state   <= ST_HALT;
                        running <= 1'b0;
                    end else begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            step     <= 1'b1;
                            if (pend_v && (pending != reverse_dir(dir))) begin
                                dir <= pending;
                            end
                            // Reversals are dropped, not kept for later.
                            pend_v <= 1'b0;
                        end else begin
                            tick_cnt <= tick_cnt + TICK_ONE;
                        end
                        // Placed after the commit so a key accepted on a step
                        // edge survives for the following step.
                        if (accept) begin
                            pending <= acc_dir;
                            pend_v  <= 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (start && !game_over && !win) begin
                        state    <= ST_RUN;
                        running  <= 1'b1;
                        dir      <= DIR_RIGHT;
                        tick_cnt <= '0;
                        pend_v   <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controle_direcao.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_direcao
// Description : Scoreboard bench for controle_direcao (TICK_DIV=4,
//               STABLE=2). Expected step pulses (edge number and heading)
//               are queued by the stimulus; a monitor pops one per pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_direcao;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       w = 1'b0, a = 1'b0, s_k = 1'b0, d = 1'b0;
    logic       game_over = 1'b0, win = 1'b0;
    logic [1:0] dir;
    logic       step;
    logic       running;

    int         ecnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         sb_edge[$];
    logic [1:0] sb_dir[$];
    int         base;

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    controle_direcao #(
        .TICK_DIV (4),
        .STABLE   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .w         (w),
        .a         (a),
        .s         (s_k),
        .d         (d),
        .game_over (game_over),
        .win       (win),
        .dir       (dir),
        .step      (step),
        .running   (running)
    );

    // Advance n edges; returns 2 time units after the last edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Return once edge e has happened; inputs set now are sampled at e+1.
    task automatic go_to(input int e);
        while (ecnt < e) cyc(1);
    endtask

    task automatic exp_step(input int e, input logic [1:0] dd);
        sb_edge.push_back(e);
        sb_dir.push_back(dd);
    endtask

    // Compares {running, step, dir}.
    task automatic check(input string name, input logic [3:0] exp_v);
        logic [3:0] act;
        act = {running, step, dir};
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at edge %0d: {running,step,dir} got %b expected %b",
                     name, ecnt, act, exp_v);
        end
    endtask

    // Monitor: every step pulse must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        int         e;
        logic [1:0] dd;
        if (step === 1'b1) begin
            n_tests++;
            if (sb_edge.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_step at edge %0d dir %b", ecnt, dir);
            end else begin
                e  = sb_edge.pop_front();
                dd = sb_dir.pop_front();
                if (e != ecnt || dir !== dd) begin
                    n_fail++;
                    $display("FAIL step: got edge %0d dir %b expected edge %0d dir %b",
                             ecnt, dir, e, dd);
                end
            end
        end
    end

    initial begin
        // 1. Reset and idle with keys toggling.
        cyc(2);
        check("reset", 4'b0001);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            {w, a, s_k, d} = 4'(i + 3);
            cyc(1);
            check("idle_keys", 4'b0001);
        end
        {w, a, s_k, d} = 4'b0000;

        // 2..5: entry edge is base; steps every 4 edges after it.
        start = 1'b1;
        base  = ecnt + 1;
        exp_step(base + 4,  2'b01);
        exp_step(base + 8,  2'b01);
        exp_step(base + 12, 2'b01);
        exp_step(base + 16, 2'b10);   // s accepted
        exp_step(base + 20, 2'b10);   // w reversal dropped
        exp_step(base + 24, 2'b10);
        exp_step(base + 28, 2'b10);   // single-cycle a, w+d ignored
        exp_step(base + 32, 2'b10);
        exp_step(base + 36, 2'b01);   // w overwritten by d
        exp_step(base + 40, 2'b01);   // s accepted on step edge waits
        exp_step(base + 44, 2'b10);
        cyc(1);
        start = 1'b0;
        check("run_entry", 4'b1001);

        go_to(base + 12); s_k = 1'b1;
        go_to(base + 14); s_k = 1'b0;
        go_to(base + 16); w = 1'b1;
        go_to(base + 18); w = 1'b0;
        go_to(base + 24); a = 1'b1;
        go_to(base + 25); a = 1'b0; w = 1'b1; d = 1'b1;
        go_to(base + 29); w = 1'b0; d = 1'b0;
        go_to(base + 31); w = 1'b1;
        go_to(base + 33); w = 1'b0; d = 1'b1;
        go_to(base + 35); d = 1'b0;
        go_to(base + 38); s_k = 1'b1;
        go_to(base + 40); s_k = 1'b0;

        // 6. game_over sampled on the would-be step edge.
        go_to(base + 47); game_over = 1'b1;
        go_to(base + 48);
        check("halt_no_step", 4'b0010);
        go_to(base + 49); start = 1'b1; w = 1'b1;
        go_to(base + 50);
        check("halt_hold", 4'b0010);
        game_over = 1'b0; w = 1'b0;
        go_to(base + 51);
        check("restart", 4'b1001);
        start = 1'b0; s_k = 1'b1;
        exp_step(base + 55, 2'b10);
        go_to(base + 53); s_k = 1'b0;
        go_to(base + 56);
        check("after_restart_step", 4'b1010);

        // Reset lands on a step edge: no pulse, back to IDLE.
        go_to(base + 58); rst_n = 1'b0;
        go_to(base + 59);
        check("reset_mid_run", 4'b0001);
        cyc(1);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check("idle_after_reset", 4'b0001);
        end

        n_tests++;
        if (sb_edge.size() != 0) begin
            n_fail++;
            $display("FAIL missing_steps: got %0d left in queue, expected 0",
                     sb_edge.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
